fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of the synchronous FIFO among `NUM_REQ` producers. It grants one producer at a time for bursts of up to `MAX_BURST` beats and registers the winning data onto the FIFO `wr_en`/`data_in` pins. It throttles grants from the FIFO `full`/`almostfull` flags so that the FIFO never sees a write while full. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshake plus FIFO write-side bundle.
// master = producers/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  modport master (
    output req_valid,
    output req_data,
    output fifo_full,
    output fifo_almostfull,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_data_in,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  fifo_full,
    input  fifo_almostfull,
    output req_ready,
    output fifo_wr_en,
    output fifo_data_in,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add beat/stall statistics counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [15:0]                stat_count,
  output logic [15:0]                stat_stall,
`endif
  fifo_wr_arbiter_if.slave           bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [3:0] MB4 = 4'(MAX_BURST);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        last_q, last_d;
  logic [IDW-1:0]        cand, sel;
  logic                  cand_vld;
  logic [3:0]            beat_q, beat_d, beat_inc;
  logic                  space_ok;
  logic                  rdy_en;
  logic                  sel_vld;
  logic                  xfer;
  logic [FIFO_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    ready;
  logic                  wr_en_q;
  logic [FIFO_WIDTH-1:0] data_q;

  // A write already in flight will consume the last free slot.
  assign space_ok = !bus.fifo_full
                  && !(bus.fifo_almostfull && wr_en_q);

  assign beat_inc = beat_q + 4'd1;

  // Round-robin search starting just after the last owner.
  always_comb begin
    int idx;
    idx      = 0;
    cand     = '0;
    cand_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_REQ;
      if (!cand_vld && bus.req_valid[idx]) begin
        cand_vld = 1'b1;
        cand     = IDW'(idx);
      end
    end
  end

  assign sel = (state_q == BURST) ? owner_q : cand;

  assign rdy_en = rst_n && space_ok
               && ((state_q == BURST) || cand_vld);

  // Select the producer being served and build the ready vector.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) begin
        sel_vld  = bus.req_valid[i];
        sel_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        ready[i] = rdy_en;
      end
    end
  end

  assign xfer = rdy_en && sel_vld;

  // Next-state: grant, beat counting and release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (xfer) begin
          owner_d = cand;
          if (MAX_BURST == 1) begin
            last_d = cand;
          end else begin
            state_d = BURST;
            beat_d  = 4'd1;
          end
        end
      end
      (state_q == BURST): begin
        if (!sel_vld) begin
          state_d = IDLE;
          last_d  = owner_q;
          beat_d  = '0;
        end else if (xfer) begin
          if (beat_inc == MB4) begin
            state_d = IDLE;
            last_d  = owner_q;
            beat_d  = '0;
          end else begin
            beat_d = beat_inc;
          end
        end
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Registered write strobe and data toward the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        data_q <= sel_data;
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.grant_id     = owner_q;
  assign bus.busy         = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] beat_ctr [NUM_REQ];
  logic [15:0] stall_q;
  logic        stall;

  assign stall = rst_n && sel_vld && !space_ok;

  // Saturating per-producer beat counters and stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beat_ctr[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && sel == IDW'(i)
            && beat_ctr[i] != 16'hFFFF) begin
          beat_ctr[i] <= beat_ctr[i] + 16'd1;
        end
      end
      if (stall && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  // Read-out mux for the selected producer counter.
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_sel == IDW'(i)) begin
        stat_count = beat_ctr[i];
      end
    end
  end

  assign stat_stall = stall_q;
`endif

endmodule
